// File: rtl/ddr3_refresh_scheduler_if.sv
// Refresh scheduler <-> command sequencer signal bundle.
// The master is the controller side; the slave is the scheduler.
interface ddr3_refresh_scheduler_if;
  logic       init_done;
  logic       refresh_en;
  logic       ref_ack;
  logic       ref_req;
  logic       ref_urgent;
  logic       block_cmds;
  logic [3:0] ref_debt;
  logic       ref_overflow;

  modport master (
    output init_done, refresh_en, ref_ack,
    input  ref_req, ref_urgent, block_cmds, ref_debt, ref_overflow
  );

  modport slave (
    input  init_done, refresh_en, ref_ack,
    output ref_req, ref_urgent, block_cmds, ref_debt, ref_overflow
  );
endinterface

// File: rtl/ddr3_refresh_scheduler.sv
// DDR3 auto-refresh scheduler: tREFI timing, refresh debt tracking with
// postponement limit, and command blocking during tRFC.
//
// state | meaning
// S_OFF | DRAM not initialised; everything cleared, no counting
// S_RUN | normal operation, REF requested while debt is non-zero
// S_RFC | tRFC wait after an accepted REF; CPU commands blocked
module ddr3_refresh_scheduler #(
  parameter int T_REFI       = 3120,
  parameter int T_RFC        = 64,
  parameter int MAX_POSTPONE = 8,
  parameter int CNT_W        = 12
) (
  input logic                     cpu_ck,
  input logic                     cpu_reset,
  ddr3_refresh_scheduler_if.slave sched
);

  localparam int         RFC_W    = $clog2(T_RFC);
  localparam logic [3:0] DEBT_MAX = 4'(MAX_POSTPONE);

  typedef enum logic [1:0] {S_OFF, S_RUN, S_RFC} state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   refi_cnt, refi_n;
  logic [RFC_W-1:0]   rfc_cnt, rfc_n;
  logic [3:0]         debt, debt_n;
  logic               ovf_q, ovf_n;
  logic               req_q, urgent_q, block_q;
  logic               counting, tick, ack_ok;

  // Next-state computation; outputs are registered from these values below.
  always_comb begin
    state_n  = state;
    refi_n   = refi_cnt;
    rfc_n    = rfc_cnt;
    debt_n   = debt;
    ovf_n    = ovf_q;
    counting = (state != S_OFF) && sched.refresh_en;
    tick     = counting && (refi_cnt == CNT_W'(T_REFI - 1));
    // An ack is only meaningful while we are actually asking for a REF.
    ack_ok   = sched.ref_ack && req_q;

    if (!sched.init_done) begin
      state_n = S_OFF;
      refi_n  = '0;
      rfc_n   = '0;
      debt_n  = '0;
      ovf_n   = 1'b0;
    end else begin
      if (counting)
        refi_n = tick ? '0 : refi_cnt + 1'b1;

      // Debt saturates at the postponement limit; a tick lost there is flagged.
      if (tick && !ack_ok) begin
        if (debt == DEBT_MAX)
          ovf_n = 1'b1;
        else
          debt_n = debt + 4'd1;
      end else if (ack_ok && !tick) begin
        debt_n = debt - 4'd1;
      end

      case (state)
        S_OFF: state_n = S_RUN;
        S_RUN: begin
          if (ack_ok) begin
            state_n = S_RFC;
            rfc_n   = RFC_W'(T_RFC - 1);
          end
        end
        S_RFC: begin
          if (rfc_cnt == '0)
            state_n = S_RUN;
          else
            rfc_n = rfc_cnt - 1'b1;
        end
        default: state_n = S_OFF;
      endcase
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge cpu_ck or posedge cpu_reset) begin
    if (cpu_reset) begin
      state    <= S_OFF;
      refi_cnt <= '0;
      rfc_cnt  <= '0;
      debt     <= '0;
      ovf_q    <= 1'b0;
      req_q    <= 1'b0;
      urgent_q <= 1'b0;
      block_q  <= 1'b0;
    end else begin
      state    <= state_n;
      refi_cnt <= refi_n;
      rfc_cnt  <= rfc_n;
      debt     <= debt_n;
      ovf_q    <= ovf_n;
      req_q    <= (state_n == S_RUN) && (debt_n != 4'd0);
      urgent_q <= (debt_n == DEBT_MAX);
      block_q  <= (state_n == S_RFC) || (debt_n == DEBT_MAX);
    end
  end

  assign sched.ref_req      = req_q;
  assign sched.ref_urgent   = urgent_q;
  assign sched.block_cmds   = block_q;
  assign sched.ref_debt     = debt;
  assign sched.ref_overflow = ovf_q;

endmodule

// File: tb/tb_ddr3_refresh_scheduler.sv
// Scoreboard bench for ddr3_refresh_scheduler: stimulus predicts each
// cycle's outputs with a behavioural model and queues them; a monitor
// pops and compares one entry after every rising edge.
module tb_ddr3_refresh_scheduler;
  localparam int T_REFI = 16;
  localparam int T_RFC  = 4;
  localparam int MAXP   = 3;

  logic cpu_ck    = 1'b0;
  logic cpu_reset = 1'b1;

  ddr3_refresh_scheduler_if bus ();

  ddr3_refresh_scheduler #(
    .T_REFI(T_REFI), .T_RFC(T_RFC), .MAX_POSTPONE(MAXP), .CNT_W(4)
  ) dut (
    .cpu_ck   (cpu_ck),
    .cpu_reset(cpu_reset),
    .sched    (bus)
  );

  always #5 cpu_ck = ~cpu_ck;

  typedef struct packed {
    logic       req;
    logic       urg;
    logic       blk;
    logic [3:0] debt;
    logic       ovf;
  } obs_t;

  obs_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Behavioural model: enabled-cycle count within the interval, owed
  // refreshes, remaining blocked tRFC cycles, sticky overflow.
  bit   m_on;
  int   m_elapsed;
  int   m_debt;
  int   m_rfc_left;
  bit   m_ovf;
  obs_t m_out;

  task automatic model_edge(input bit rst, input bit init, input bit en, input bit ack);
    bit tick;
    bit acc;
    int nd;
    if (rst || !init) begin
      m_on = 0; m_elapsed = 0; m_debt = 0; m_rfc_left = 0; m_ovf = 0;
    end else if (!m_on) begin
      m_on = 1;
    end else begin
      acc  = ack && m_out.req;
      tick = en && (m_elapsed == T_REFI - 1);
      if (en) m_elapsed = (m_elapsed + 1) % T_REFI;
      nd = m_debt + int'(tick) - int'(acc);
      if (nd > MAXP) begin
        m_debt = MAXP;
        m_ovf  = 1;
      end else begin
        m_debt = nd;
      end
      if (acc) m_rfc_left = T_RFC;
      else if (m_rfc_left > 0) m_rfc_left--;
    end
    m_out.req  = m_on && (m_rfc_left == 0) && (m_debt != 0);
    m_out.urg  = (m_debt == MAXP);
    m_out.blk  = (m_rfc_left > 0) || (m_debt == MAXP);
    m_out.debt = 4'(m_debt);
    m_out.ovf  = m_ovf;
  endtask

  // Drive one cycle of inputs, predict the next edge, wait until 3 after it.
  task automatic cyc(input bit rst, input bit init, input bit en, input bit ack);
    cpu_reset      = rst;
    bus.init_done  = init;
    bus.refresh_en = en;
    bus.ref_ack    = ack;
    model_edge(rst, init, en, ack);
    exp_q.push_back(m_out);
    @(posedge cpu_ck);
    #3;
  endtask

  function automatic obs_t sample();
    obs_t o;
    o.req  = bus.ref_req;
    o.urg  = bus.ref_urgent;
    o.blk  = bus.block_cmds;
    o.debt = bus.ref_debt;
    o.ovf  = bus.ref_overflow;
    return o;
  endfunction

  // Monitor: one expected entry per rising edge.
  initial begin
    obs_t e;
    obs_t a;
    forever begin
      @(posedge cpu_ck);
      #1;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL queue_underflow t=%0t: no expected entry for this edge", $time);
      end else begin
        e = exp_q.pop_front();
        a = sample();
        if (a !== e) begin
          n_bad++;
          $display("FAIL outputs t=%0t actual req=%b urg=%b blk=%b debt=%0d ovf=%b required req=%b urg=%b blk=%b debt=%0d ovf=%b",
                   $time, a.req, a.urg, a.blk, a.debt, a.ovf, e.req, e.urg, e.blk, e.debt, e.ovf);
        end
      end
    end
  end

  initial begin
    int   ack_div;
    int   guard;
    obs_t a;
    m_on = 0; m_elapsed = 0; m_debt = 0; m_rfc_left = 0; m_ovf = 0; m_out = '0;

    repeat (3) cyc(1, 0, 0, 0);

    // Free-running with no acks: debt climbs to the limit, then overflows.
    repeat (70) cyc(0, 1, 1, 0);

    // Randomised phases with varying ack pressure and enable gaps.
    for (int ph = 0; ph < 16; ph++) begin
      case ($urandom_range(0, 2))
        0: ack_div = 0;
        1: ack_div = 40;
        default: ack_div = 4;
      endcase
      for (int i = 0; i < 200; i++) begin
        bit r, in, en, ak;
        r  = ($urandom_range(0, 499) == 0);
        in = ($urandom_range(0, 149) != 0);
        en = ($urandom_range(0, 3) != 0);
        ak = (ack_div != 0) && ($urandom_range(0, ack_div - 1) == 0);
        cyc(r, in, en, ak);
      end
    end

    // Enable held low for 10 cycles mid-interval.
    repeat (5) cyc(0, 1, 1, 0);
    repeat (10) cyc(0, 1, 0, 0);
    repeat (30) cyc(0, 1, 1, 0);

    // Build up debt 3 in S_RUN, accept one REF -> S_RFC with debt 2.
    guard = 0;
    while (!(m_debt == MAXP && m_out.req) && guard < 300) begin
      cyc(0, 1, 1, 0);
      guard++;
    end
    cyc(0, 1, 1, 1);
    cyc(0, 1, 1, 1);

    // Async reset in S_RFC: outputs must clear with no clock edge.
    cpu_reset = 1'b1;
    #1;
    a = sample();
    n_cmp++;
    if (a !== obs_t'(0)) begin
      n_bad++;
      $display("FAIL async_reset t=%0t actual req=%b urg=%b blk=%b debt=%0d ovf=%b required all 0",
               $time, a.req, a.urg, a.blk, a.debt, a.ovf);
    end
    repeat (2) cyc(1, 1, 1, 0);

    // Run to overflow, then drop init_done for one cycle.
    repeat (80) cyc(0, 1, 1, 0);
    cyc(0, 0, 1, 0);
    repeat (40) cyc(0, 1, 1, 0);

    // Acks while not requesting must be ignored.
    repeat (10) cyc(0, 1, 1, 1);
    repeat (20) cyc(0, 1, 1, ($urandom_range(0, 1) == 1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
